// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem
//  Description : EX/MEM pipeline register. Latches the execute-stage result
//                and load/store operands, applies stall / flush, and keeps
//                the partial multiply-accumulate product and step count that
//                EX needs across a stalled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem #(
   parameter int REG_W  = 32,
   parameter int ADDR_W = 5,
   parameter int OP_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           stall,
   input  logic                 flush,
   input  logic [ADDR_W-1:0]    ex_wd,
   input  logic                 ex_wreg,
   input  logic [REG_W-1:0]     ex_wdata,
   input  logic                 ex_whilo,
   input  logic [REG_W-1:0]     ex_hi,
   input  logic [REG_W-1:0]     ex_lo,
   input  logic [OP_W-1:0]      ex_aluop,
   input  logic [REG_W-1:0]     ex_mem_addr,
   input  logic [REG_W-1:0]     ex_reg2,
   input  logic [2*REG_W-1:0]   hilo_i,
   input  logic [1:0]           cnt_i,
   output logic [ADDR_W-1:0]    mem_wd,
   output logic                 mem_wreg,
   output logic [REG_W-1:0]     mem_wdata,
   output logic                 mem_whilo,
   output logic [REG_W-1:0]     mem_hi,
   output logic [REG_W-1:0]     mem_lo,
   output logic [OP_W-1:0]      mem_aluop,
   output logic [REG_W-1:0]     mem_mem_addr,
   output logic [REG_W-1:0]     mem_reg2,
   output logic                 mem_valid,
   output logic [2*REG_W-1:0]   hilo_o,
   output logic [1:0]           cnt_o
);

   // Stall vector decode: EX stalled alone inserts a bubble into MEM,
   // EX and MEM stalled together freeze the register.
   logic ex_stall;
   logic mem_stall;

   assign ex_stall  = stall[3];
   assign mem_stall = stall[4];

   // Stage register: reset > flush > bubble > hold > advance.
   // stall[3]==0 with stall[4]==1 falls through to advance.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         mem_wd       <= '0;
         mem_wreg     <= 1'b0;
         mem_wdata    <= '0;
         mem_whilo    <= 1'b0;
         mem_hi       <= '0;
         mem_lo       <= '0;
         mem_aluop    <= '0;
         mem_mem_addr <= '0;
         mem_reg2     <= '0;
         mem_valid    <= 1'b0;
         hilo_o       <= '0;
         cnt_o        <= '0;
      end else if (ex_stall && !mem_stall) begin
         // Bubble to MEM, but keep EX's partial product for its next cycle.
         mem_wd       <= '0;
         mem_wreg     <= 1'b0;
         mem_wdata    <= '0;
         mem_whilo    <= 1'b0;
         mem_hi       <= '0;
         mem_lo       <= '0;
         mem_aluop    <= '0;
         mem_mem_addr <= '0;
         mem_reg2     <= '0;
         mem_valid    <= 1'b0;
         hilo_o       <= hilo_i;
         cnt_o        <= cnt_i;
      end else if (!ex_stall) begin
         // Advance: the multi-cycle op (if any) has completed in EX.
         mem_wd       <= ex_wd;
         mem_wreg     <= ex_wreg;
         mem_wdata    <= ex_wdata;
         mem_whilo    <= ex_whilo;
         mem_hi       <= ex_hi;
         mem_lo       <= ex_lo;
         mem_aluop    <= ex_aluop;
         mem_mem_addr <= ex_mem_addr;
         mem_reg2     <= ex_reg2;
         mem_valid    <= 1'b1;
         hilo_o       <= '0;
         cnt_o        <= '0;
      end
      // Remaining case (both stalled): every register holds.
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem
//  Description : Directed self-checking bench for the EX/MEM pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_whilo;
   logic [31:0] ex_hi;
   logic [31:0] ex_lo;
   logic [7:0]  ex_aluop;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_reg2;
   logic [63:0] hilo_i;
   logic [1:0]  cnt_i;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr;
   logic [31:0] mem_reg2;
   logic        mem_valid;
   logic [63:0] hilo_o;
   logic [1:0]  cnt_o;

   int tests;
   int fails;

   ex_mem #(.REG_W(32), .ADDR_W(5), .OP_W(8)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a full set of stage inputs.
   task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [63:0] hl, input logic [1:0] cnt);
      ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_whilo = whilo;
      ex_hi = hi; ex_lo = lo; ex_aluop = aluop; ex_mem_addr = addr;
      ex_reg2 = reg2; hilo_i = hl; cnt_i = cnt;
   endtask

   task automatic test_reset();
      logic [255:0] all_out;
      rst = 1'b0; stall = 6'b0; flush = 1'b0;
      drive(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1111_1111, 32'h2222_2222,
            8'hFF, 32'h3333_3333, 32'h4444_4444, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
      tick();
      tick();
      all_out = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
                 mem_mem_addr, mem_reg2, mem_valid, hilo_o, cnt_o};
      tests++;
      if (all_out !== '0) begin
         fails++; $display("FAIL reset_all_zero: got %h expected 0", all_out);
      end
      rst = 1'b1;
      drive(5'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0, 64'h0, 2'd0);
      tick();
      tests++;
      if ({mem_wdata, mem_wd, mem_wreg, mem_valid} !== {32'h1234_5678, 5'd5, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL reset_first_advance: got wdata=%h wd=%0d wreg=%b valid=%b expected 12345678/5/1/1",
                  mem_wdata, mem_wd, mem_wreg, mem_valid);
      end
   endtask

   task automatic test_bubble();
      stall = 6'b001111;
      drive(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h5, 32'h6, 8'h11, 32'h100, 32'h200,
            64'h0000_0001_FFFF_FFFE, 2'd1);
      tick();
      tests++;
      if ({mem_wreg, mem_wdata, mem_valid, mem_wd, mem_whilo} !== '0) begin
         fails++;
         $display("FAIL bubble_outputs: got wreg=%b wdata=%h valid=%b wd=%0d whilo=%b expected all 0",
                  mem_wreg, mem_wdata, mem_valid, mem_wd, mem_whilo);
      end
      tests++;
      if (hilo_o !== 64'h0000_0001_FFFF_FFFE || cnt_o !== 2'd1) begin
         fails++;
         $display("FAIL bubble_saved: got hilo_o=%h cnt_o=%0d expected 00000001fffffffe/1",
                  hilo_o, cnt_o);
      end
   endtask

   task automatic test_madd_release();
      stall = 6'b000000;
      drive(5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2, 8'h2C, 32'h0, 32'h0,
            64'hAAAA_BBBB_CCCC_DDDD, 2'd2);
      tick();
      tests++;
      if ({mem_whilo, mem_hi, mem_lo, mem_valid} !== {1'b1, 32'h1, 32'h2, 1'b1}) begin
         fails++;
         $display("FAIL madd_release_hilo: got whilo=%b hi=%h lo=%h valid=%b expected 1/1/2/1",
                  mem_whilo, mem_hi, mem_lo, mem_valid);
      end
      tests++;
      if (cnt_o !== 2'd0 || hilo_o !== 64'h0) begin
         fails++;
         $display("FAIL madd_release_clear: got cnt_o=%0d hilo_o=%h expected 0/0", cnt_o, hilo_o);
      end
   endtask

   task automatic test_hold();
      stall = 6'b000000;
      drive(5'd7, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h77, 32'h88, 8'h23, 32'h1000_0004,
            32'hCAFE_F00D, 64'h0, 2'd0);
      tick();
      stall = 6'b011111;
      for (int i = 0; i < 3; i++) begin
         drive(5'(i + 1), 1'b0, 32'h0101_0101 * (i + 1), 1'b1, 32'h9, 32'h9, 8'h99,
               32'h0, 32'h0, 64'h1234, 2'd2);
         tick();
         tests++;
         if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
              mem_mem_addr, mem_reg2, mem_valid, hilo_o, cnt_o} !==
             {5'd7, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h77, 32'h88, 8'h23,
              32'h1000_0004, 32'hCAFE_F00D, 1'b1, 64'h0, 2'd0}) begin
            fails++;
            $display("FAIL hold_edge%0d: got wd=%0d wdata=%h aluop=%h addr=%h reg2=%h valid=%b cnt_o=%0d expected 7/a5a5a5a5/23/10000004/cafef00d/1/0",
                     i, mem_wd, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2, mem_valid, cnt_o);
         end
      end
   endtask

   task automatic test_flush();
      stall = 6'b000000;
      drive(5'd3, 1'b1, 32'h5555_AAAA, 1'b1, 32'h1, 32'h1, 8'h01, 32'h4, 32'h8, 64'h0, 2'd0);
      tick();
      flush = 1'b1;
      stall = 6'b001111;
      drive(5'd4, 1'b1, 32'h6666_7777, 1'b1, 32'h2, 32'h3, 8'h05, 32'h8, 32'hC,
            64'hFFFF_0000_FFFF_0000, 2'd1);
      tick();
      flush = 1'b0;
      tests++;
      if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
           mem_mem_addr, mem_reg2, mem_valid, hilo_o, cnt_o} !== '0) begin
         fails++;
         $display("FAIL flush_priority: got wdata=%h valid=%b hilo_o=%h cnt_o=%0d expected all 0",
                  mem_wdata, mem_valid, hilo_o, cnt_o);
      end
   endtask

   task automatic test_reset_mid_stall();
      stall = 6'b001111;
      drive(5'd1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0,
            64'h0000_0002_0000_0003, 2'd1);
      tick();
      stall = 6'b011111;
      tick();
      tests++;
      if (cnt_o !== 2'd1 || hilo_o !== 64'h0000_0002_0000_0003) begin
         fails++;
         $display("FAIL hold_keeps_madd: got cnt_o=%0d hilo_o=%h expected 1/0000000200000003",
                  cnt_o, hilo_o);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      stall = 6'b011111;
      tests++;
      if (cnt_o !== 2'd0 || hilo_o !== 64'h0 || mem_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_stall: got cnt_o=%0d hilo_o=%h valid=%b expected 0/0/0",
                  cnt_o, hilo_o, mem_valid);
      end
   endtask

   // Illegal stall combination behaves as Advance.
   task automatic test_illegal_stall();
      stall = 6'b010000;
      drive(5'd0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 8'h42, 32'hFFFF_FFFC,
            32'h8000_0001, 64'h5, 2'd1);
      tick();
      tests++;
      if ({mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2, mem_valid, cnt_o} !==
          {5'd0, 1'b1, 32'h0BAD_F00D, 8'h42, 32'hFFFF_FFFC, 32'h8000_0001, 1'b1, 2'd0}) begin
         fails++;
         $display("FAIL illegal_stall_advance: got wd=%0d wreg=%b wdata=%h aluop=%h addr=%h reg2=%h valid=%b cnt_o=%0d",
                  mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2, mem_valid, cnt_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] data_tab [3];
      logic [4:0]  wd_tab   [3];
      data_tab = '{32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
      wd_tab   = '{5'd1, 5'd16, 5'd31};
      stall = 6'b000000;
      for (int i = 0; i < 3; i++) begin
         drive(wd_tab[i], i[0], data_tab[i], 1'b0, ~data_tab[i], data_tab[i], 8'(i + 8'h30),
               data_tab[i] ^ 32'hFFFF_0000, ~data_tab[i], 64'h9, 2'd3);
         tick();
         tests++;
         if ({mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2, mem_valid} !==
             {wd_tab[i], i[0], data_tab[i], ~data_tab[i], data_tab[i], 8'(i + 8'h30),
              data_tab[i] ^ 32'hFFFF_0000, ~data_tab[i], 1'b1}) begin
            fails++;
            $display("FAIL back_to_back_%0d: got wd=%0d wdata=%h hi=%h lo=%h aluop=%h expected wd=%0d wdata=%h",
                     i, mem_wd, mem_wdata, mem_hi, mem_lo, mem_aluop, wd_tab[i], data_tab[i]);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_bubble();
      test_madd_release();
      test_hold();
      test_flush();
      test_reset_mid_stall();
      test_illegal_stall();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
